div_issue_ctrl: RTL
===================

# div_issue_ctrl

Sequencer between the EX stage and the shared multi-cycle divider of the ALU. It latches a div/mod request, issues a one-cycle start to the divider, and stalls EX while the divider runs. It returns the selected quotient or remainder and handles pipeline flushes, divide-by-zero and divider timeouts. It sits beside the ALU in EX and owns the divider's start and operand inputs.

## Interface
- `TIMEOUT`, default 40: maximum cycles allowed in WAIT/DRAIN before the watchdog fires; must be at least 34.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `es_div_req`  in  1  the EX instruction is div/mod; held stable while `es_div_stall`=1.
- `es_div_signed`  in  1  1 = signed, 0 = unsigned.
- `es_div_mod`  in  1  0 = return quotient, 1 = return remainder.
- `es_src1`, `es_src2`  in  32 each  dividend and divisor.
- `es_flush`  in  1  exception/ertn flush of the EX instruction.
- `ms_allowin`  in  1  MEM stage can accept the EX result.
- `es_div_stall`  out  1  hold the EX stage.
- `es_div_done`  out  1  `es_div_result` is valid this cycle.
- `es_div_result`  out  32  registered quotient or remainder.
- `dvr_en`  out  1  one-cycle start pulse to the divider.
- `dvr_signed`  out  1  registered copy of `es_div_signed`.
- `dvr_src1`, `dvr_src2`  out  32 each  registered operands, stable from ISSUE until the result returns.
- `dvr_valid`  in  1  divider result valid, single-cycle pulse.
- `dvr_quot`, `dvr_rem`  in  32 each  divider outputs.
- `dvr_timeout`  out  1  sticky watchdog error; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN. A 6-bit watchdog counter `wd_cnt` runs in WAIT and DRAIN.
- Reset values: state = IDLE; all outputs 0; operand registers, result register and `wd_cnt` = 0.
- `es_div_stall` = (IDLE & `es_div_req` & !`es_flush`) | ISSUE | WAIT | (DRAIN & `es_div_req`). It is 0 in DONE.
- IDLE
  - `es_div_req` & `es_flush`: ignored, stay in IDLE.
  - `es_div_req` & `es_src2`≠0: latch operands, `es_div_signed` and `es_div_mod`; go to ISSUE.
  - `es_div_req` & `es_src2`=0: no divider launch. Result = `es_src1` if mod, else 0. Go to DONE.
- ISSUE: `dvr_en`=1 for exactly this cycle. Clear `wd_cnt`. Go to WAIT, or DRAIN if `es_flush`.
- WAIT
  - `dvr_valid`: capture `dvr_rem` if mod, else `dvr_quot`, into the result register; go to DONE.
  - `es_flush` without `dvr_valid`: go to DRAIN.
  - `es_flush` together with `dvr_valid`: go to IDLE and discard the result.
  - `wd_cnt` = `TIMEOUT`-1: set `dvr_timeout`, result = 0, go to DONE.
- DRAIN: the divider cannot abort, so its pending result is awaited and discarded. `dvr_valid` or watchdog expiry returns to IDLE; watchdog expiry also sets `dvr_timeout`. A new request waits in DRAIN with stall=1.
- DONE: `es_div_done`=1 and `es_div_result` is valid.
  - `ms_allowin`=1: go to IDLE.
  - `ms_allowin`=0: stay in DONE; result and done held.
  - `es_flush` in DONE: go to IDLE, `es_div_done` forced to 0.
- `dvr_valid` outside WAIT/DRAIN is ignored.
- Signed overflow (0x80000000 / -1) is passed through from the divider unchanged.

## Timing
- Normal request seen at cycle 0 in IDLE:
  - cycle 1: ISSUE, `dvr_en`=1.
  - cycles 2..: WAIT.
  - `dvr_valid` at cycle k: DONE at cycle k+1, `es_div_done`=1, `es_div_stall`=0.
- Total latency = divider latency + 2 cycles.
- Divide-by-zero: request at cycle 0 → DONE at cycle 1.
- After DONE with `ms_allowin`=1 the block is in IDLE on the next cycle. A back-to-back request issues one cycle later.
- `resetn` low at any time: immediate return to reset values. An in-flight divider result arriving after reset is ignored because state is IDLE.

## Test plan
- Unsigned 100/7, mod=0; divider returns after 33 cycles → one `dvr_en` pulse in cycle 1, `es_div_done` with result 14 in cycle 35, stall high for cycles 0..34.
- Signed −100 mod 7 → result 0xFFFFFFFE (−2); `dvr_signed`=1 during ISSUE.
- `es_src2`=0 with `es_src1`=0x1234, mod=1 → no `dvr_en`, DONE in cycle 1 with result 0x1234. With mod=0 the result is 0.
- `es_flush` during WAIT at cycle 10, new request at cycle 11 → stall held until `dvr_valid` discards the old result; the new `dvr_en` follows afterwards. The stale quotient never appears on `es_div_result`.
- DONE with `ms_allowin`=0 for 3 cycles → result and `es_div_done` held stable for 4 cycles; IDLE after `ms_allowin` rises.
- Divider never returns, `TIMEOUT`=40 → `dvr_timeout`=1 and DONE with result 0 at cycle 41. `dvr_timeout` stays 1 until `resetn` is asserted mid-operation, which clears all outputs.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Sequencer between EX and the shared multi-cycle divider: latches a div/mod
// request, pulses the divider start, stalls EX and returns quotient or remainder.
module div_issue_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_div_req,
  input  logic        es_div_signed,
  input  logic        es_div_mod,
  input  logic [31:0] es_src1,
  input  logic [31:0] es_src2,
  input  logic        es_flush,
  input  logic        ms_allowin,
  output logic        es_div_stall,
  output logic        es_div_done,
  output logic [31:0] es_div_result,
  output logic        dvr_en,
  output logic        dvr_signed,
  output logic [31:0] dvr_src1,
  output logic [31:0] dvr_src2,
  input  logic        dvr_valid,
  input  logic [31:0] dvr_quot,
  input  logic [31:0] dvr_rem,
  output logic        dvr_timeout
);

  localparam int unsigned DW  = 32;
  localparam int unsigned WDW = 6;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            mod_q, mod_d;
  logic            done_q, done_d;
  logic            en_d, signed_d, timeout_d;
  logic [DW-1:0]   src1_d, src2_d, result_d;
  logic [WDW-1:0]  wd_cnt, wd_d;

  // Stall depends on the live request so EX holds in the same cycle it is seen.
  assign es_div_stall = ((state_q == S_IDLE) && es_div_req && !es_flush) ||
                        (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                        ((state_q == S_DRAIN) && es_div_req);

  // A flushed instruction must never be reported as completed.
  assign es_div_done = done_q && !es_flush;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    mod_d     = mod_q;
    done_d    = 1'b0;
    en_d      = 1'b0;
    signed_d  = dvr_signed;
    timeout_d = dvr_timeout;
    src1_d    = dvr_src1;
    src2_d    = dvr_src2;
    result_d  = es_div_result;
    wd_d      = wd_cnt;

    case (state_q)
      S_IDLE: begin
        if (es_div_req && !es_flush) begin
          if (es_src2 != '0) begin
            src1_d   = es_src1;
            src2_d   = es_src2;
            signed_d = es_div_signed;
            mod_d    = es_div_mod;
            en_d     = 1'b1;
            wd_d     = '0;
            state_d  = S_ISSUE;
          end else begin
            result_d = es_div_mod ? es_src1 : '0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_ISSUE: begin
        wd_d    = wd_cnt + WDW'(1);
        state_d = es_flush ? S_DRAIN : S_WAIT;
      end

      S_WAIT: begin
        wd_d = wd_cnt + WDW'(1);
        if (dvr_valid) begin
          if (es_flush) begin
            state_d = S_IDLE;
          end else begin
            result_d = mod_q ? dvr_rem : dvr_quot;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end else if (wd_cnt == WD_LAST) begin
          timeout_d = 1'b1;
          if (es_flush) begin
            state_d = S_IDLE;
          end else begin
            result_d = '0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end else if (es_flush) begin
          state_d = S_DRAIN;
        end
      end

      // The divider cannot abort: wait out its result and drop it.
      S_DRAIN: begin
        wd_d = wd_cnt + WDW'(1);
        if (dvr_valid) begin
          state_d = S_IDLE;
        end else if (wd_cnt == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_DONE: begin
        if (es_flush || ms_allowin) begin
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      mod_q         <= 1'b0;
      done_q        <= 1'b0;
      dvr_en        <= 1'b0;
      dvr_signed    <= 1'b0;
      dvr_timeout   <= 1'b0;
      dvr_src1      <= '0;
      dvr_src2      <= '0;
      es_div_result <= '0;
      wd_cnt        <= '0;
    end else begin
      state_q       <= state_d;
      mod_q         <= mod_d;
      done_q        <= done_d;
      dvr_en        <= en_d;
      dvr_signed    <= signed_d;
      dvr_timeout   <= timeout_d;
      dvr_src1      <= src1_d;
      dvr_src2      <= src2_d;
      es_div_result <= result_d;
      wd_cnt        <= wd_d;
    end
  end

endmodule
